// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Data-memory request/response bus between the MEM-stage access
//               controller (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
    logic        memReq_out;
    logic        memWe_out;
    logic [63:0] memAddr_out;
    logic [63:0] memWData_out;
    logic [7:0]  memBe_out;
    logic        memReady_in;
    logic [63:0] memRData_in;

    modport master (
        output memReq_out,
        output memWe_out,
        output memAddr_out,
        output memWData_out,
        output memBe_out,
        input  memReady_in,
        input  memRData_in
    );

    modport slave (
        input  memReq_out,
        input  memWe_out,
        input  memAddr_out,
        input  memWData_out,
        input  memBe_out,
        output memReady_in,
        output memRData_in
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage load/store controller. Checks alignment, issues one
//               doubleword-aligned request per instruction with byte enables,
//               stalls the pipeline while the memory is busy, extracts and
//               extends load data and flags misalignment or memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           memRead_in,
    input  wire logic           memWrite_in,
    input  wire logic [2:0]     funct3_in,
    input  wire logic [63:0]    addr_in,
    input  wire logic [63:0]    writeData_in,
    output logic                stall_out,
    output logic                wbBubble_out,
    output logic [63:0]         readData_out,
    output logic                fault_out,
    mem_access_ctrl_if.master   mem
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    localparam int                 c_CNT_W    = 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic [7:0]         r_be;
    logic [2:0]         r_funct3;
    logic [2:0]         r_off;
    logic [63:0]        r_rdata;

    logic [1:0]         w_state_nxt;
    logic               w_mem_op;
    logic               w_aligned;
    logic [7:0]         w_size_mask;
    logic               w_start;
    logic               w_misalign;
    logic               w_complete;
    logic               w_timeout;
    logic [63:0]        w_lane;
    logic [63:0]        w_load_ext;

    assign w_mem_op = memRead_in | memWrite_in;

    // Alignment rule and byte-lane mask are both keyed by the access size in funct3[1:0]
    always_comb begin
        w_aligned   = 1'b1;
        w_size_mask = 8'h01;
        case (funct3_in[1:0])
            2'b00: begin
                w_aligned   = 1'b1;
                w_size_mask = 8'h01;
            end
            2'b01: begin
                w_aligned   = ~addr_in[0];
                w_size_mask = 8'h03;
            end
            2'b10: begin
                w_aligned   = (addr_in[1:0] == 2'b00);
                w_size_mask = 8'h0F;
            end
            default: begin
                w_aligned   = (addr_in[2:0] == 3'b000);
                w_size_mask = 8'hFF;
            end
        endcase
    end

    // Next-state decode plus the combinational stall/fault outputs
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_misalign  = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_mem_op) begin
                    if (w_aligned) begin
                        w_start     = 1'b1;
                        w_state_nxt = c_ACCESS;
                    end else begin
                        w_misalign  = 1'b1;
                        w_state_nxt = c_DONE;
                    end
                end
            end
            c_ACCESS: begin
                // A ready arriving on the last allowed cycle still completes normally
                if (mem.memReady_in) begin
                    w_complete  = 1'b1;
                    w_state_nxt = c_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                // One release cycle; inputs ignored so the held instruction is not reissued
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
        stall_out    = ((r_state == c_IDLE) && w_mem_op) || (r_state == c_ACCESS);
        wbBubble_out = stall_out;
        fault_out    = w_misalign | w_timeout;
    end

    // Load data: select the addressed lane, then sign/zero extend by access type
    always_comb begin
        w_lane     = mem.memRData_in >> {r_off, 3'b000};
        w_load_ext = w_lane;
        case (r_funct3)
            3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_load_ext = {56'd0, w_lane[7:0]};
            3'b101:  w_load_ext = {48'd0, w_lane[15:0]};
            3'b110:  w_load_ext = {32'd0, w_lane[31:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter: counts ACCESS cycles, zero everywhere else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == c_ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Request latch: address, data and lanes frozen for the whole ACCESS state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
        end else if (w_start) begin
            r_we     <= memWrite_in;
            r_addr   <= {addr_in[63:3], 3'b000};
            r_wdata  <= writeData_in << {addr_in[2:0], 3'b000};
            r_be     <= w_size_mask << addr_in[2:0];
            r_funct3 <= funct3_in;
            r_off    <= addr_in[2:0];
        end
    end

    // Read data: updated by completed loads, cleared by any fault, kept by stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_complete && !r_we) begin
            r_rdata <= w_load_ext;
        end else if (w_misalign || w_timeout) begin
            r_rdata <= '0;
        end
    end

    assign mem.memReq_out   = (r_state == c_ACCESS);
    assign mem.memWe_out    = r_we;
    assign mem.memAddr_out  = r_addr;
    assign mem.memWData_out = r_wdata;
    assign mem.memBe_out    = r_be;
    assign readData_out     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl: directed vector table,
//               reset-during-access sequence and randomized accesses checked
//               against an arithmetic reference model of load/store behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int c_T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead_in;
    logic        memWrite_in;
    logic [2:0]  funct3_in;
    logic [63:0] addr_in;
    logic [63:0] writeData_in;
    logic        stall_out;
    logic        wbBubble_out;
    logic [63:0] readData_out;
    logic        fault_out;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] model_rd = '0;

    mem_access_ctrl_if mem_bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(c_T)) dut (
        .clk          (clk),
        .reset        (reset),
        .memRead_in   (memRead_in),
        .memWrite_in  (memWrite_in),
        .funct3_in    (funct3_in),
        .addr_in      (addr_in),
        .writeData_in (writeData_in),
        .stall_out    (stall_out),
        .wbBubble_out (wbBubble_out),
        .readData_out (readData_out),
        .fault_out    (fault_out),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        logic [63:0] exp_rd;
        logic [7:0]  exp_be;
        logic [63:0] exp_wd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: lane select by byte offset, mask to size, extend for signed loads
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int          sz;
        logic [63:0] v;
        logic [63:0] mask;
        sz   = 1 << f3[1:0];
        v    = rdata >> (8 * int'(addr[2:0]));
        mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        v    = v & mask;
        if (!f3[2] && sz != 8 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction held in EX/MEM from the detect cycle through the release cycle
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int delay,
                              input logic [63:0] exp_rd, input logic [7:0] exp_be,
                              input logic [63:0] exp_wd, input logic exp_mis, input string tag);
        int  k;
        bit  fin;
        memRead_in   = rd;
        memWrite_in  = wr;
        funct3_in    = f3;
        addr_in      = addr;
        writeData_in = wdata;
        @(negedge clk);
        chk({tag, " detect stall"}, 64'(stall_out), 64'd1);
        chk({tag, " detect bubble"}, 64'(wbBubble_out), 64'd1);
        chk({tag, " detect req"}, 64'(mem_bus.memReq_out), 64'd0);
        chk({tag, " detect fault"}, 64'(fault_out), 64'(exp_mis));
        @(posedge clk); #1;
        if (!exp_mis) begin
            k   = 0;
            fin = 1'b0;
            while (!fin) begin
                mem_bus.memReady_in = (k == delay);
                mem_bus.memRData_in = (k == delay) ? rdata : {$urandom, $urandom};
                @(negedge clk);
                chk({tag, " acc req"}, 64'(mem_bus.memReq_out), 64'd1);
                chk({tag, " acc stall"}, 64'(stall_out), 64'd1);
                chk({tag, " acc we"}, 64'(mem_bus.memWe_out), 64'(wr));
                chk({tag, " acc addr"}, mem_bus.memAddr_out, addr & ~64'd7);
                chk({tag, " acc be"}, 64'(mem_bus.memBe_out), 64'(exp_be));
                chk({tag, " acc wdata"}, mem_bus.memWData_out, exp_wd);
                chk({tag, " acc fault"}, 64'(fault_out), 64'((k == c_T - 1) && (k != delay)));
                if (k == delay || k == c_T - 1) fin = 1'b1;
                k++;
                @(posedge clk); #1;
                mem_bus.memReady_in = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, " done stall"}, 64'(stall_out), 64'd0);
        chk({tag, " done bubble"}, 64'(wbBubble_out), 64'd0);
        chk({tag, " done req"}, 64'(mem_bus.memReq_out), 64'd0);
        chk({tag, " done fault"}, 64'(fault_out), 64'd0);
        chk({tag, " done rdata"}, readData_out, exp_rd);
        model_rd = exp_rd;
        @(posedge clk); #1;
        memRead_in  = 1'b0;
        memWrite_in = 1'b0;
        @(negedge clk);
        chk({tag, " after req"}, 64'(mem_bus.memReq_out), 64'd0);
        chk({tag, " after stall"}, 64'(stall_out), 64'd0);
        @(posedge clk); #1;
    endtask

    // Random access: expectations derived from size/offset arithmetic and the wait budget
    task automatic random_access(input int idx);
        logic        rd, wr, mis;
        logic [2:0]  f3;
        logic [63:0] addr, wdata, rdata, exp_rd, exp_wd;
        logic [7:0]  exp_be;
        int          sz, off, delay;
        wr    = ($urandom_range(0, 1) == 1);
        rd    = !wr;
        f3    = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
        sz    = 1 << f3[1:0];
        addr  = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) addr = addr & ~64'(sz - 1);
        off   = int'(addr[2:0]);
        wdata = {$urandom, $urandom};
        if (sz < 8) wdata = wdata & ((64'd1 << (8 * sz)) - 64'd1);
        rdata = {$urandom, $urandom};
        delay = $urandom_range(0, c_T + 1);
        mis   = (off % sz) != 0;
        exp_be = 8'(((1 << sz) - 1) << off);
        exp_wd = wdata << (8 * off);
        if (mis || delay >= c_T) exp_rd = 64'd0;
        else if (wr)             exp_rd = model_rd;
        else                     exp_rd = model_load(f3, addr, rdata);
        run_access(rd, wr, f3, addr, wdata, rdata, delay, exp_rd, exp_be, exp_wd, mis,
                   $sformatf("rnd%0d", idx));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 0, 3'b011, 64'h1000, 0, 64'h1122334455667788, 0,
                     64'h1122334455667788, 8'hFF, 0, 0};
        vecs[1]  = '{1, 0, 3'b000, 64'h1003, 0, 64'h0000000080000000, 0,
                     64'hFFFFFFFFFFFFFF80, 8'h08, 0, 0};
        vecs[2]  = '{1, 0, 3'b100, 64'h1003, 0, 64'h0000000080000000, 0,
                     64'h80, 8'h08, 0, 0};
        vecs[3]  = '{0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'h5555, 1,
                     64'h80, 8'hC0, 64'hBEEF000000000000, 0};
        vecs[4]  = '{1, 0, 3'b010, 64'h1002, 0, 0, 0, 64'h0, 8'h00, 0, 1};
        vecs[5]  = '{1, 0, 3'b010, 64'h1004, 0, 64'h89ABCDEF00000000, 3,
                     64'hFFFFFFFF89ABCDEF, 8'hF0, 0, 0};
        vecs[6]  = '{1, 0, 3'b011, 64'h3000, 0, 0, 99, 64'h0, 8'hFF, 0, 0};
        vecs[7]  = '{1, 0, 3'b101, 64'h1006, 0, 64'hFEDC000000000000, 1,
                     64'hFEDC, 8'hC0, 0, 0};
        vecs[8]  = '{0, 1, 3'b011, 64'h4008, 64'h0123456789ABCDEF, 0, 0,
                     64'hFEDC, 8'hFF, 64'h0123456789ABCDEF, 0};
        vecs[9]  = '{1, 0, 3'b001, 64'h1001, 0, 0, 0, 64'h0, 8'h00, 0, 1};
        vecs[10] = '{1, 0, 3'b110, 64'h1004, 0, 64'h8000000000000000, 2,
                     64'h80000000, 8'hF0, 0, 0};
        vecs[11] = '{0, 1, 3'b000, 64'h5007, 64'hAB, 0, 0,
                     64'h80000000, 8'h80, 64'hAB00000000000000, 0};

        reset = 1'b1;
        memRead_in = 1'b0;
        memWrite_in = 1'b0;
        funct3_in = 3'b000;
        addr_in = '0;
        writeData_in = '0;
        mem_bus.memReady_in = 1'b0;
        mem_bus.memRData_in = '0;

        // Reset values before any clock edge
        #1;
        chk("rst req", 64'(mem_bus.memReq_out), 64'd0);
        chk("rst we", 64'(mem_bus.memWe_out), 64'd0);
        chk("rst addr", mem_bus.memAddr_out, 64'd0);
        chk("rst wdata", mem_bus.memWData_out, 64'd0);
        chk("rst be", 64'(mem_bus.memBe_out), 64'd0);
        chk("rst rdata", readData_out, 64'd0);
        chk("rst fault", 64'(fault_out), 64'd0);
        chk("rst stall", 64'(stall_out), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       vecs[i].rdata, vecs[i].delay, vecs[i].exp_rd, vecs[i].exp_be,
                       vecs[i].exp_wd, vecs[i].exp_mis, $sformatf("vec%0d", i));
        end

        // Reset in the second ACCESS cycle abandons the load and clears outputs at once
        memRead_in = 1'b1;
        funct3_in  = 3'b011;
        addr_in    = 64'h6000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid req before", 64'(mem_bus.memReq_out), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid req", 64'(mem_bus.memReq_out), 64'd0);
        chk("mid rdata", readData_out, 64'd0);
        chk("mid addr", mem_bus.memAddr_out, 64'd0);
        chk("mid be", 64'(mem_bus.memBe_out), 64'd0);
        chk("mid fault", 64'(fault_out), 64'd0);
        chk("mid stall held op", 64'(stall_out), 64'd1);
        memRead_in = 1'b0;
        #1;
        chk("mid stall no op", 64'(stall_out), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        model_rd = '0;
        @(negedge clk);
        chk("mid idle req", 64'(mem_bus.memReq_out), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                funct3_in = 3'($urandom_range(0, 7));
                addr_in   = {$urandom, $urandom};
                @(negedge clk);
                chk($sformatf("gap%0d stall", i), 64'(stall_out), 64'd0);
                chk($sformatf("gap%0d fault", i), 64'(fault_out), 64'd0);
                chk($sformatf("gap%0d rdata", i), readData_out, model_rd);
                @(posedge clk); #1;
            end
            random_access(i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, the maximum number of ACCESS cycles spent waiting for memReady_in before a fault; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-004 memRead_in  input  1  the MEM-stage instruction (EX/MEM register output) is a load.
REQ-005 memWrite_in  input  1  the MEM-stage instruction is a store; never asserted together with memRead_in.
REQ-006 funct3_in  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-007 addr_in  input  64  byte address (ALUResult of the MEM stage).
REQ-008 writeData_in  input  64  store data, right-aligned.
REQ-009 memReq_out  output  1  request to data memory; Moore output of ACCESS state.
REQ-010 memWe_out / memAddr_out / memWData_out / memBe_out  output  1/64/64/8  latched write flag, doubleword-aligned address (addr[2:0]=0), lane-shifted store data, byte-lane enables.
REQ-011 memReady_in / memRData_in  input  1/64  memory completion and aligned doubleword read data.
REQ-012 stall_out  output  1  holds PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 wbBubble_out  output  1  forces regWrite_in and ecall_in of the MEM/WB register to 0.
REQ-014 readData_out  output  64  extracted, extended load data; feeds readData_in of MEM/WB.
REQ-015 fault_out  output  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-016 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-017 IDLE: if memRead_in|memWrite_in, SHALL check alignment (H: addr[0]=0, W: addr[1:0]=0, D: addr[2:0]=0); aligned -> ACCESS, misaligned -> DONE with fault_out=1 in the transition cycle; otherwise stay IDLE.
REQ-018 On IDLE->ACCESS, SHALL latch memWe_out, memAddr_out={addr_in[63:3],3'b000}, funct3 and addr_in[2:0]; memBe_out = size mask (B 1, H 3, W F, D FF) shifted left by addr_in[2:0]; memWData_out = writeData_in shifted left by 8*addr_in[2:0].
REQ-019 ACCESS: memReq_out=1; wait counter increments each cycle from 0; memReady_in=1 -> capture memRData_in into readData_out (REQ-021), go DONE.
REQ-020 ACCESS timeout: counter reaching TIMEOUT_CYCLES-1 with memReady_in=0 -> fault_out=1 for that cycle, readData_out=0, go DONE; memReady_in in the same cycle wins (normal completion, no fault).
REQ-021 Load extraction: byte lane = memRData_in >> 8*addr[2:0]; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD unchanged; stores leave readData_out unchanged.
REQ-022 DONE: memReq_out=0, stall_out=0, wbBubble_out=0 for exactly one cycle, then IDLE; inputs ignored in DONE, so the same instruction never issues twice.
REQ-023 stall_out = (IDLE and (memRead_in|memWrite_in)) or ACCESS; combinational, asserted in the first cycle of an access.
REQ-024 wbBubble_out = stall_out.
REQ-025 Non-memory instruction in IDLE: stall_out=0, wbBubble_out=0, zero added latency.
REQ-026 Minimum load/store latency: 3 cycles (IDLE-detect, ACCESS with immediate ready, DONE); each extra wait cycle adds 1.
REQ-027 memReq_out held constant with latched address/data for the whole ACCESS state; memory SHALL NOT see a new request until the FSM returns to ACCESS.

Reset
REQ-028 On reset: state IDLE, counter 0, memReq_out=0, memWe_out=0, memAddr_out=0, memWData_out=0, memBe_out=0, readData_out=0, fault_out=0; stall_out/wbBubble_out follow REQ-023 from IDLE.
REQ-029 Reset asserted mid-ACCESS SHALL drop memReq_out asynchronously in the same cycle; the pending access is abandoned and readData_out cleared.

Verification
REQ-030 LD addr 0x1000, memReady_in on first ACCESS cycle, RData 0x1122334455667788 -> stall 2 cycles, readData_out=0x1122334455667788 in DONE, fault_out=0.
REQ-031 LB addr 0x1003, RData 0x00000000_80000000 -> readData_out=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
REQ-032 SH addr 0x2006, writeData 0xBEEF -> memBe_out=0xC0, memWData_out=0xBEEF000000000000, memWe_out=1, memAddr_out=0x2000.
REQ-033 LW addr 0x1002 -> no memReq_out, fault_out pulse, DONE next, readData_out=0.
REQ-034 TIMEOUT_CYCLES=4, memReady_in never -> memReq_out high 4 cycles, fault_out on 4th, then DONE; repeat with ready on 4th cycle -> no fault.
REQ-035 Reset pulse asserted in second ACCESS cycle -> memReq_out=0 before next edge, state IDLE, all outputs at REQ-028 values.
